// File: rtl/send_line_data_stream.sv
// AXI4-Lite slave that queues DATA-register writes in a FIFO and streams them out
// on an AXI4-Stream master, closing each line of LINE_LEN words with TLAST.
module send_line_data_stream #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH         = 64,
    parameter int LEN_WIDTH          = 12
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            irq
);
    localparam int ADDR_LSB = 2;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]       DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_LEN    = 3'd1,
        REG_DATA   = 3'd2,
        REG_STATUS = 3'd3,
        REG_LCNT   = 3'd4
    } reg_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] wd,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : cur[b*8 +: 8];
        return res;
    endfunction

    logic                 awready_q, awready_d, bvalid_q, bvalid_d;
    logic                 arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 enable_q, enable_d, empty_ie_q, empty_ie_d, soft_clear_q, soft_clear_d;
    logic [LEN_WIDTH-1:0] line_len_q, line_len_d, cur_len_q, cur_len_d, len_use;
    logic [LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 overflow_q, overflow_d;
    logic [31:0]          line_cnt_q, line_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [31:0]          tdata_q, tdata_d;

    logic        wr_en, rd_en, fifo_empty, fifo_full, tx_hs, fifo_pop, fifo_push, push_ok;
    reg_e        wr_sel, rd_sel;
    logic [31:0] ctrl_merged, len_merged, status_word;
    logic        unused_ok;

    // NOTE: FIFO storage carries no reset; the pointers and count alone define what is valid.
    logic [31:0] mem [FIFO_DEPTH];

    always_ff @(posedge s00_axi_aclk) begin
        if (push_ok) mem[wr_ptr_q] <= s00_axi_wdata;
    end

    always_comb begin
        // NOTE: every _d starts from a default so no path through this block can infer a latch.
        awready_d    = 1'b0;
        arready_d    = 1'b0;
        bvalid_d     = bvalid_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        enable_d     = enable_q;
        empty_ie_d   = empty_ie_q;
        soft_clear_d = 1'b0;
        line_len_d   = line_len_q;
        cur_len_d    = cur_len_q;
        word_cnt_d   = word_cnt_q;
        overflow_d   = overflow_q;
        line_cnt_d   = line_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tdata_d      = tdata_q;
        len_use      = cur_len_q;

        wr_en       = awready_q && s00_axi_awvalid && s00_axi_wvalid;
        rd_en       = arready_q && s00_axi_arvalid;
        wr_sel      = reg_e'(s00_axi_awaddr[ADDR_LSB+2:ADDR_LSB]);
        rd_sel      = reg_e'(s00_axi_araddr[ADDR_LSB+2:ADDR_LSB]);
        ctrl_merged = apply_strb({29'd0, empty_ie_q, 1'b0, enable_q}, s00_axi_wdata, s00_axi_wstrb);
        len_merged  = apply_strb(32'(line_len_q), s00_axi_wdata, s00_axi_wstrb);
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == DEPTH_CNT);
        tx_hs       = tvalid_q && m_axis_tready;
        fifo_pop    = enable_q && !fifo_empty && (!tvalid_q || m_axis_tready) && !soft_clear_q;
        fifo_push   = wr_en && (wr_sel == REG_DATA);
        push_ok     = fifo_push && (!fifo_full || fifo_pop);
        status_word = {16'(count_q) + 16'(tvalid_q), 13'd0, overflow_q, fifo_full, fifo_empty};

        if (!awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q) awready_d = 1'b1;
        if (wr_en)               bvalid_d = 1'b1;
        else if (s00_axi_bready) bvalid_d = 1'b0;

        if (!arready_q && s00_axi_arvalid && !rvalid_q) arready_d = 1'b1;
        if (rd_en) begin
            rvalid_d = 1'b1;
            case (rd_sel)
                REG_CTRL:   rdata_d = {29'd0, empty_ie_q, 1'b0, enable_q};
                REG_LEN:    rdata_d = 32'(line_len_q);
                REG_STATUS: rdata_d = status_word;
                REG_LCNT:   rdata_d = line_cnt_q;
                default:    rdata_d = '0;
            endcase
        end else if (s00_axi_rready) begin
            rvalid_d = 1'b0;
        end

        if (tx_hs) begin
            word_cnt_d = tlast_q ? '0 : word_cnt_q + 1'b1;
            if (tlast_q) line_cnt_d = line_cnt_q + 1'b1;
        end

        // The post-handshake count decides whether the loaded word opens a new line.
        if (fifo_pop) begin
            if (word_cnt_d == '0) begin
                len_use   = line_len_q;
                cur_len_d = line_len_q;
            end
            tvalid_d = 1'b1;
            tdata_d  = mem[rd_ptr_q];
            tlast_d  = (word_cnt_d == len_use - 1'b1);
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (tx_hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (fifo_push && !push_ok) overflow_d = 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({push_ok, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_en) begin
            case (wr_sel)
                REG_CTRL: begin
                    enable_d     = ctrl_merged[0];
                    soft_clear_d = ctrl_merged[1];
                    empty_ie_d   = ctrl_merged[2];
                end
                REG_LEN:    line_len_d = (len_merged[LEN_WIDTH-1:0] == '0) ? LEN_ONE
                                                                           : len_merged[LEN_WIDTH-1:0];
                REG_STATUS: if (s00_axi_wstrb[0] && s00_axi_wdata[2]) overflow_d = 1'b0;
                REG_LCNT:   line_cnt_d = '0;
                default:    ;
            endcase
        end

        // Soft clear drops queued words but lets a presented word finish as a line end.
        if (soft_clear_q) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            word_cnt_d = '0;
            overflow_d = 1'b0;
            if (tvalid_q && !tx_hs) tlast_d = 1'b1;
        end
    end

    // NOTE: state is updated only here, with non-blocking assigns from the _d values.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            enable_q     <= 1'b0;
            empty_ie_q   <= 1'b0;
            soft_clear_q <= 1'b0;
            line_len_q   <= LEN_ONE;
            cur_len_q    <= LEN_ONE;
            word_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            line_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
        end else begin
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            enable_q     <= enable_d;
            empty_ie_q   <= empty_ie_d;
            soft_clear_q <= soft_clear_d;
            line_len_q   <= line_len_d;
            cur_len_q    <= cur_len_d;
            word_cnt_q   <= word_cnt_d;
            overflow_q   <= overflow_d;
            line_cnt_q   <= line_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tdata_q      <= tdata_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tdata    = tdata_q;
    assign irq             = overflow_q || ((count_q == '0) && empty_ie_q);

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         ctrl_merged[31:3], len_merged[31:LEN_WIDTH]};
endmodule

// File: tb/tb_send_line_data_stream.sv
// Self-checking bench for send_line_data_stream: register table, AXIS scoreboard,
// overflow, back-pressure, soft clear and asynchronous reset sequences.
module tb_send_line_data_stream;
    localparam int DEPTH = 64;
    localparam logic [4:0] A_CTRL = 5'h00, A_LEN = 5'h04, A_DATA = 5'h08,
                           A_STAT = 5'h0C, A_LCNT = 5'h10;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, tdata;
    logic        tlast, tvalid, tready = 1'b0, irq;

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    logic tv_at_b, sc_window = 1'b0, tog_done;

    typedef struct { logic [4:0] addr; logic [31:0] exp; } rd_vec_t;
    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    rd_vec_t rd_tab [8];
    beat_t   exp_q [$];
    beat_t   mon_e;
    logic        prev_hold = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    send_line_data_stream #(.FIFO_DEPTH(DEPTH)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        check("awready_seen", 32'(awready), 32'd1);
        check("wready_with_awready", 32'(wready), 32'(awready));
        acc_cyc = cyc;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 50);
        check("bvalid_seen", 32'(bvalid), 32'd1);
        tv_at_b = tvalid;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        axi_write(a, d, 4'hF);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        check("arready_seen", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        check("rvalid_seen", 32'(rvalid), 32'd1);
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(name, v, exp);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stream monitor: scoreboard pops on every handshake, held beats must not change.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_tvalid", 32'(tvalid), 32'd1);
                check("hold_tdata", tdata, prev_data);
                if (!sc_window) check("hold_tlast", 32'(tlast), 32'(prev_last));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL axis_extra: got beat 0x%08h, none expected", tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("axis_tdata", tdata, mon_e.data);
                    check("axis_tlast", 32'(tlast), 32'(mon_e.last));
                end
            end
            prev_hold = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
        end
    end

    initial begin
        int sent, n, lat;
        rd_tab[0] = '{addr: A_CTRL, exp: 32'h0000_0000};
        rd_tab[1] = '{addr: A_LEN,  exp: 32'h0000_0001};
        rd_tab[2] = '{addr: A_DATA, exp: 32'h0000_0000};
        rd_tab[3] = '{addr: A_STAT, exp: 32'h0000_0001};
        rd_tab[4] = '{addr: A_LCNT, exp: 32'h0000_0000};
        rd_tab[5] = '{addr: 5'h14,  exp: 32'h0000_0000};
        rd_tab[6] = '{addr: 5'h18,  exp: 32'h0000_0000};
        rd_tab[7] = '{addr: 5'h1C,  exp: 32'h0000_0000};

        // Reset state and register map.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outs", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp,
                                      tvalid, tlast, irq}), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_tdata", tdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wr(5'h18, 32'hFFFF_FFFF);
        for (int k = 0; k < 8; k++)
            rd_check($sformatf("reset_read_%02h", rd_tab[k].addr), rd_tab[k].addr, rd_tab[k].exp);

        // Two lines of four words with the sink always ready.
        tready = 1'b1;
        wr(A_LEN, 32'd4);
        wr(A_CTRL, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            expect_beat(32'(i), (i % 4) == 0);
            wr(A_DATA, 32'(i));
        end
        wait_drain();
        rd_check("lines_after_8", A_LCNT, 32'd2);
        rd_check("status_drained", A_STAT, 32'h0000_0001);

        // Overflow with the output stage disabled.
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) wr(A_DATA, 32'h1000 + 32'(i));
        check("disabled_no_tvalid", 32'(tvalid), 32'd0);
        rd_check("status_overflow", A_STAT, {16'(DEPTH), 16'h0006});
        check("irq_overflow", 32'(irq), 32'd1);
        wr(A_STAT, 32'h4);
        rd_check("status_w1c", A_STAT, {16'(DEPTH), 16'h0002});
        check("irq_after_w1c", 32'(irq), 32'd0);
        wr(A_CTRL, 32'h2);
        rd_check("status_soft_clear", A_STAT, 32'h0000_0001);
        rd_check("ctrl_sc_reads_0", A_CTRL, 32'h0);
        wr(A_CTRL, 32'h4);
        check("irq_empty_ie", 32'(irq), 32'd1);
        rd_check("ctrl_empty_ie", A_CTRL, 32'h4);

        // LINE_LEN zero substitution and byte strobes.
        wr(A_LEN, 32'd0);
        rd_check("len_zero_is_1", A_LEN, 32'd1);
        axi_write(A_LEN, 32'h0000_0ABC, 4'hF);
        rd_check("len_full", A_LEN, 32'h0000_0ABC);
        axi_write(A_LEN, 32'hFFFF_FF12, 4'b0001);
        rd_check("len_byte0", A_LEN, 32'h0000_0A12);
        axi_write(A_LEN, 32'hFFFF_FFFF, 4'b0010);
        rd_check("len_byte1", A_LEN, 32'h0000_0F12);

        // Lines of three with the sink toggling ready every cycle.
        wr(A_CTRL, 32'h1);
        check("irq_ie_off", 32'(irq), 32'd0);
        wr(A_LEN, 32'd3);
        wr(A_LCNT, 32'h1234);
        rd_check("lcnt_cleared", A_LCNT, 32'd0);
        tready = 1'b0;
        tog_done = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    expect_beat(32'h200 + 32'(i), (i % 3) == 0);
                    wr(A_DATA, 32'h200 + 32'(i));
                end
                wait_drain();
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk); #1;
                    tready = ~tready;
                end
            end
        join
        tready = 1'b1;
        rd_check("lines_after_toggle", A_LCNT, 32'd2);

        // Soft clear with the third word of a four-word line held.
        tready = 1'b0;
        wr(A_LEN, 32'd4);
        for (int i = 1; i <= 4; i++) wr(A_DATA, 32'h300 + 32'(i));
        expect_beat(32'h301, 1'b0);
        expect_beat(32'h302, 1'b0);
        expect_beat(32'h303, 1'b1);
        tready = 1'b1;
        sent = 0;
        n = 0;
        while (sent < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (tvalid && tready) sent++;
        end
        check("two_beats_sent", 32'(sent), 32'd2);
        @(posedge clk); #1;
        tready = 1'b0;
        repeat (2) @(negedge clk);
        check("held_word_data", tdata, 32'h303);
        check("held_word_tlast_pre", 32'(tlast), 32'd0);
        sc_window = 1'b1;
        wr(A_CTRL, 32'h3);
        @(negedge clk);
        check("held_word_tlast_forced", 32'(tlast), 32'd1);
        check("held_word_data_post", tdata, 32'h303);
        @(posedge clk); #1;
        sc_window = 1'b0;
        tready = 1'b1;
        wait_drain();
        rd_check("status_after_sc", A_STAT, 32'h0000_0001);
        for (int i = 1; i <= 4; i++) begin
            expect_beat(32'h400 + 32'(i), i == 4);
            wr(A_DATA, 32'h400 + 32'(i));
        end
        wait_drain();
        rd_check("lines_after_sc", A_LCNT, 32'd4);

        // Write-to-valid latency, then reset in the middle of a line.
        tready = 1'b0;
        wr(A_DATA, 32'h501);
        check("tvalid_low_at_b", 32'(tv_at_b), 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!tvalid && n < 20);
        lat = cyc - acc_cyc;
        check("accept_to_tvalid", 32'(lat), 32'd2);
        wr(A_DATA, 32'h502);
        check("tvalid_before_reset", 32'(tvalid), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("tvalid_async_drop", 32'(tvalid), 32'd0);
        check("tdata_async_clear", tdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_check("status_post_reset", A_STAT, 32'h0000_0001);
        rd_check("len_post_reset", A_LEN, 32'd1);
        rd_check("lcnt_post_reset", A_LCNT, 32'd0);
        rd_check("ctrl_post_reset", A_CTRL, 32'd0);
        check("no_tvalid_post_reset", 32'(tvalid), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
